// File: rtl/qpu_ifu_prefetch_pkg.sv
// Shared sizes and helpers for the QPU instruction fetch unit.
package qpu_ifu_prefetch_pkg;

  localparam int QPU_PC_SIZE    = 32;
  localparam int QPU_INSTR_SIZE = 32;
  localparam int QPU_PC_INCR    = 4;

  // Width of a counter that must hold every value 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/qpu_ifu_ibuf.sv
// Prefetch buffer: synchronous FIFO with a registered head entry and a
// single-cycle clear.
module qpu_ifu_ibuf
  import qpu_ifu_prefetch_pkg::*;
#(
  parameter int DW    = 64,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [DW-1:0]           push_data,
  input  logic                    pop,
  input  logic                    clear,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic [DW-1:0]           head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_w(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0] count_after_pop;
  logic          do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign do_pop          = pop && (count != '0);
  assign rd_ptr_nxt      = do_pop ? ptr_inc(rd_ptr) : rd_ptr;
  assign count_after_pop = count - CW'(do_pop);

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && count == CW'(DEPTH)));
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr <= rd_ptr_nxt;
      count  <= count_after_pop + CW'(push);
      // Head bypasses the array when the incoming entry becomes the oldest.
      if (push && count_after_pop == '0) head <= push_data;
      else if (do_pop)                   head <= mem[rd_ptr_nxt];
    end
  end

  // NOTE: storage is not reset; pointers and count alone define valid entries.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/qpu_ifu_prefetch.sv
// QPU instruction fetch unit: credit-limited prefetch into a small buffer,
// with reset vector, flush redirect (stale responses dropped) and halt.
module qpu_ifu_prefetch
  import qpu_ifu_prefetch_pkg::*;
#(
  parameter int PC_W       = QPU_PC_SIZE,
  parameter int INSTR_W    = QPU_INSTR_SIZE,
  parameter int PC_INCR    = QPU_PC_INCR,
  parameter int OUTS_MAX   = 2,
  parameter int IBUF_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PC_W-1:0]    pc_rtvec,
  output logic               ifu_req_valid,
  input  logic               ifu_req_ready,
  output logic [PC_W-1:0]    ifu_req_pc,
  output logic               ifu_req_seq,
  input  logic               ifu_rsp_valid,
  output logic               ifu_rsp_ready,
  input  logic [INSTR_W-1:0] ifu_rsp_instr,
  output logic               ifu_o_valid,
  input  logic               ifu_o_ready,
  output logic [INSTR_W-1:0] ifu_o_ir,
  output logic [PC_W-1:0]    ifu_o_pc,
  input  logic               pipe_flush_req,
  input  logic [PC_W-1:0]    pipe_flush_pc,
  output logic               pipe_flush_ack,
  input  logic               ifu_halt_req,
  output logic               ifu_halt_ack,
  output logic [PC_W-1:0]    inspect_pc
);

  localparam int OW = cnt_w(OUTS_MAX);
  localparam int BW = cnt_w(IBUF_DEPTH);
  localparam int SW = cnt_w(OUTS_MAX + IBUF_DEPTH);
  localparam int DW = INSTR_W + PC_W;

  logic            first_r, redir_r, halt_ack_r;
  logic [PC_W-1:0] req_pc_r, rsp_pc_r, req_pc_nxt;
  logic [OW-1:0]   outs_cnt, drop_cnt;
  logic [BW-1:0]   buf_cnt;
  logic [DW-1:0]   buf_head;
  logic [SW-1:0]   credit_sum;
  logic            req_hs, rsp_drop, buf_push, buf_pop;

  assign req_pc_nxt     = first_r ? pc_rtvec : req_pc_r;
  assign ifu_req_pc     = {req_pc_nxt[PC_W-1:1], 1'b0};
  assign ifu_req_seq    = ~first_r & ~redir_r;
  assign inspect_pc     = req_pc_nxt;
  assign ifu_rsp_ready  = 1'b1;
  assign pipe_flush_ack = 1'b1;
  assign ifu_halt_ack   = halt_ack_r;

  // In-flight plus buffered never exceeds the buffer, so responses always fit.
  assign credit_sum    = SW'(outs_cnt) + SW'(buf_cnt);
  assign ifu_req_valid = rst_n & ~pipe_flush_req & ~ifu_halt_req & ~halt_ack_r
                       & (outs_cnt < OW'(OUTS_MAX))
                       & (credit_sum < SW'(IBUF_DEPTH));
  assign req_hs        = ifu_req_valid & ifu_req_ready;

  assign rsp_drop    = pipe_flush_req | (drop_cnt != '0);
  assign buf_push    = ifu_rsp_valid & ~rsp_drop;
  assign ifu_o_valid = (buf_cnt != '0) & ~halt_ack_r;
  assign buf_pop     = ifu_o_valid & ifu_o_ready & ~pipe_flush_req;
  assign {ifu_o_ir, ifu_o_pc} = buf_head;

  qpu_ifu_ibuf #(
    .DW    (DW),
    .DEPTH (IBUF_DEPTH)
  ) u_ibuf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (buf_push),
    .push_data ({ifu_rsp_instr, rsp_pc_r}),
    .pop       (buf_pop),
    .clear     (pipe_flush_req),
    .count     (buf_cnt),
    .head      (buf_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_r    <= 1'b1;
      redir_r    <= 1'b0;
      halt_ack_r <= 1'b0;
      req_pc_r   <= '0;
      rsp_pc_r   <= '0;
      outs_cnt   <= '0;
      drop_cnt   <= '0;
    end else begin
      outs_cnt   <= outs_cnt + OW'(req_hs) - OW'(ifu_rsp_valid);
      halt_ack_r <= ifu_halt_req & (halt_ack_r | (outs_cnt == '0));
      if (pipe_flush_req) begin
        // outs_cnt already covers requests doomed by earlier flushes, so every
        // remaining in-flight response is stale.
        drop_cnt <= outs_cnt - OW'(ifu_rsp_valid);
        req_pc_r <= pipe_flush_pc;
        rsp_pc_r <= pipe_flush_pc;
        redir_r  <= 1'b1;
      end else begin
        if (ifu_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - OW'(1);
        if (buf_push) rsp_pc_r <= rsp_pc_r + PC_W'(PC_INCR);
        if (req_hs) begin
          req_pc_r <= ifu_req_pc + PC_W'(PC_INCR);
          first_r  <= 1'b0;
          redir_r  <= 1'b0;
          // Response PCs start at the (aligned) reset vector.
          if (first_r) rsp_pc_r <= ifu_req_pc;
        end
      end
    end
  end

endmodule
